// File: rtl/branch_pkg.sv
// Shared constants and helpers for the branch predict unit.
// 2-bit PHT counter encoding and PC-to-index extraction.
package branch_pkg;

  localparam logic [1:0] PHT_SNT = 2'd0;
  localparam logic [1:0] PHT_WNT = 2'd1;
  localparam logic [1:0] PHT_WT  = 2'd2;
  localparam logic [1:0] PHT_ST  = 2'd3;
  localparam logic [1:0] PHT_RST = PHT_WNT;

  localparam int PC_MAX = 64;

  // Word-aligned PC: drop the low 2 bits, keep idx_w bits.
  function automatic logic [PC_MAX-1:0] pht_idx(
    input logic [PC_MAX-1:0] pc,
    input int unsigned       idx_w
  );
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch, resolve and statistics signals of the branch predict unit.
// master drives the unit, slave is the unit itself.
interface branch_predict_unit_if #(
  parameter int SEL_W = 2,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  localparam int COND_NUM = 2 ** SEL_W;

  logic                predict_en_i;
  logic [PC_W-1:0]     pred_pc_i;
  logic                pred_taken_o;
  logic                res_valid_i;
  logic [PC_W-1:0]     res_pc_i;
  logic [COND_NUM-1:0] cond_i;
  logic [SEL_W-1:0]    select_i;
  logic                res_pred_i;
  logic                taken_o;
  logic                mispredict_o;
  logic                stat_clr_i;
  logic [CNT_W-1:0]    branch_cnt_o;
  logic [CNT_W-1:0]    mispred_cnt_o;

  modport master (
    output predict_en_i, pred_pc_i,
    output res_valid_i, res_pc_i,
    output cond_i, select_i, res_pred_i,
    output stat_clr_i,
    input  pred_taken_o, taken_o,
    input  mispredict_o,
    input  branch_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  predict_en_i, pred_pc_i,
    input  res_valid_i, res_pc_i,
    input  cond_i, select_i, res_pred_i,
    input  stat_clr_i,
    output pred_taken_o, taken_o,
    output mispredict_o,
    output branch_cnt_o, mispred_cnt_o
  );

endinterface

// File: rtl/branch_cond_sel.sv
// COND_NUM:1 condition-flag mux resolving branch direction.
// Generalises the old fixed 4-input select.
module branch_cond_sel #(
  parameter int SEL_W    = 2,
  parameter int COND_NUM = 2 ** SEL_W
) (
  input  logic [COND_NUM-1:0] cond,
  input  logic [SEL_W-1:0]    sel,
  output logic                taken
);

  assign taken = cond[sel];

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution, 2-bit PHT prediction and profiling counters.
// PHT is a flop array so every entry can be reset to WNT.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int IDX_W = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input logic clk_i,
  input logic rst_i,
  branch_predict_unit_if.slave bus
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [1:0]       pht [DEPTH];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             taken;
  logic             mispredict;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  assign pred_idx = IDX_W'(pht_idx(PC_MAX'(bus.pred_pc_i), IDX_W));
  assign res_idx  = IDX_W'(pht_idx(PC_MAX'(bus.res_pc_i), IDX_W));

  branch_cond_sel #(
    .SEL_W (SEL_W)
  ) u_cond_sel (
    .cond  (bus.cond_i),
    .sel   (bus.select_i),
    .taken (taken)
  );

  assign mispredict = bus.res_valid_i & (taken ^ bus.res_pred_i);

  assign bus.taken_o       = taken;
  assign bus.mispredict_o  = mispredict;
  assign bus.pred_taken_o  = bus.predict_en_i & pht[pred_idx][1];
  assign bus.branch_cnt_o  = branch_cnt;
  assign bus.mispred_cnt_o = mispred_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++)
        pht[i] <= PHT_RST;
    end else if (bus.res_valid_i) begin
      if (taken && pht[res_idx] != PHT_ST)
        pht[res_idx] <= pht[res_idx] + 2'd1;
      else if (!taken && pht[res_idx] != PHT_SNT)
        pht[res_idx] <= pht[res_idx] - 2'd1;
    end
  end

  // Clear wins over increment; counters stick at all-ones.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (bus.stat_clr_i) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (bus.res_valid_i && branch_cnt != '1)
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispredict && mispred_cnt != '1)
        mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule
